dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory (DMEM) between the core's load/store path and an external loader/debug port.
//   Sequences each access through a fixed-latency memory handshake.
//   Stalls the core (holds PC) until its access completes.
//   Sits between the core's daddr/ddata_w/ddata_r/MemRead/MemWrite signals and the DMEM macro.
// PARAMETERS
//   ADDR_W       10  DMEM word-address width (1024 words)
//   DATA_W       32  data bus width
//   WAIT_STATES  1   extra memory read-latency cycles (0..15)
// PORTS
//   CLK          in   1       clock, rising edge
//   RESET        in   1       asynchronous reset, active-high
//   core_re      in   1       core load request (MemRead)
//   core_we      in   1       core store request (MemWrite)
//   core_addr    in   ADDR_W  core address; stable while core_stall=1
//   core_wdata   in   DATA_W  core store data
//   core_rdata   out  DATA_W  load data; valid when request present and core_stall=0
//   core_stall   out  1       hold core PC/regfile write
//   ld_req       in   1       loader request; held high until ld_ack
//   ld_we        in   1       loader write (1) / read (0); qualified by ld_req
//   ld_addr      in   ADDR_W  loader address
//   ld_wdata     in   DATA_W  loader write data
//   ld_ack       out  1       1-cycle completion pulse
//   ld_rdata     out  DATA_W  loader read data; valid with ld_ack
//   mem_addr     out  ADDR_W  DMEM address
//   mem_wdata    out  DATA_W  DMEM write data
//   mem_we       out  1       DMEM write strobe
//   mem_re       out  1       DMEM read enable
//   mem_rdata    in   DATA_W  DMEM read data
//   busy         out  1       FSM not in IDLE
// BEHAVIOUR
//   Reset (async, immediate):
//     - FSM state IDLE; all outputs 0; last_grant = LOADER (core wins the first tie).
//     - Reset mid-transaction aborts the transaction; mem_we drops at once; no ld_ack is issued.
//   FSM:
//     - IDLE -> BUSY when any request is present. The winner's addr/wdata/we are registered and cnt = WAIT_STATES.
//     - BUSY: cnt decrements each cycle. When cnt==0, BUSY -> DONE and mem_rdata is captured into rdata_q.
//     - DONE -> IDLE unconditionally, so there is always one IDLE cycle between grants.
//   Memory side:
//     - mem_addr, mem_wdata and mem_re/mem_we come from registered values and are 0 in IDLE/DONE.
//     - mem_re is high for all BUSY cycles of a read.
//     - mem_we is high only in the first BUSY cycle of a write (exactly one write strobe per access).
//   Latency: WAIT_STATES+3 cycles from request seen in IDLE to completion (1 IDLE + WAIT_STATES+1 BUSY + 1 DONE).
//   Core side:
//     - core_req = core_re|core_we; core_re and core_we are never both 1.
//     - core_stall = core_req & !(state==DONE & owner==CORE), combinational.
//     - In DONE with owner CORE: core_rdata = rdata_q; otherwise core_rdata = 0.
//   Loader side:
//     - In DONE with owner LOADER: ld_ack = 1 and ld_rdata = rdata_q (write: ld_rdata = 0).
//     - ld_req still high in the following IDLE cycle is a new request.
//   Arbitration in IDLE:
//     - Single requester is granted.
//     - Both requesting: grant goes to the port that is not last_grant (round-robin); last_grant updates on each grant.
//     - A losing requester keeps waiting: core stays stalled, loader gets no ack.
//   Requests arriving in BUSY/DONE wait for IDLE; they are never dropped.
// CONFIGURATION
//   DMEM_ARB_FIXED_PRIO_EN
//     - defined: core always wins ties; last_grant is unused.
//     - undefined: round-robin as above.
// TESTING
//   1. Reset, core_we=1, addr=0x010, wdata=0xDEADBEEF, W=1 -> one mem_we pulse (cycle 1); core_stall high cycles 0-2, low cycle 3.
//   2. Core load addr=0x010 after T1 -> core_rdata=0xDEADBEEF in DONE, stall released after exactly 4 cycles; W=3 -> 6 cycles.
//   3. core_re and ld_req (read 0x020) both high from reset -> core served first, ld_ack 4 cycles later;
//      repeat the tie -> loader first. With DMEM_ARB_FIXED_PRIO_EN defined -> core first both times.
//   4. Loader write 0x3FF=0x12345678, ld_req kept high 1 cycle past ack -> second write issued, two ld_ack pulses, no lost request.
//   5. Assert RESET during BUSY of a loader write -> mem_we=0, busy=0, ld_ack=0 immediately; first access after release behaves as T1.
//   6. Random interleave of 1000 core/loader accesses vs reference memory model -> all read data match; never two mem_we in one access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port DMEM between the core load/store path and the loader/debug port.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: core always wins ties (default: round-robin ties).
module dmem_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              core_re,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam logic       OWN_CORE = 1'b0;
    localparam logic       OWN_LD   = 1'b1;

    state_t            state, state_nx;
    req_t              req_q, win;
    logic              owner_q;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              core_req, any_req, grant_core, done_core;

    assign core_req = core_re | core_we;
    assign any_req  = core_req | ld_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign grant_core = core_req;
`else
    logic last_grant;
    assign grant_core = core_req & (~ld_req | (last_grant == OWN_LD));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            last_grant <= OWN_LD;
        else if (state == IDLE && any_req)
            last_grant <= grant_core ? OWN_CORE : OWN_LD;
    end
`endif

    assign win = grant_core ? req_t'{core_we, core_addr, core_wdata}
                            : req_t'{ld_we, ld_addr, ld_wdata};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write accesses capture zero so neither read-data port leaks stale data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_q   <= '0;
            owner_q <= OWN_CORE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    req_q   <= win;
                    owner_q <= grant_core ? OWN_CORE : OWN_LD;
                    cnt     <= WS;
                end
                BUSY: begin
                    if (cnt == 4'd0) rdata_q <= req_q.we ? '0 : mem_rdata;
                    else             cnt     <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        done_core  = (state == DONE) && (owner_q == OWN_CORE);
        busy       = (state != IDLE);
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        if (state == BUSY) begin
            mem_addr  = req_q.addr;
            mem_wdata = req_q.wdata;
            mem_re    = ~req_q.we;
            mem_we    = req_q.we & (cnt == WS);
        end
        core_stall = core_req & ~done_core;
        core_rdata = done_core ? rdata_q : '0;
        ld_ack     = (state == DONE) && (owner_q == OWN_LD);
        ld_rdata   = ld_ack ? rdata_q : '0;
    end
endmodule
